alu_exec_stage: RTL
===================

Name: alu_exec_stage

Overview:
Execute-stage ALU for the MIPS64 pipeline. It sits directly downstream of the ALU-control decoder and consumes its 4-bit alucontrol code, the two operands and a destination tag. It performs the operation and registers the result with flags into a valid/ready output stage, which has a one-entry skid buffer so that backpressure from memory/writeback never drops an operation. It also keeps a free-running count of retired operations.

Parameters:
XLEN, 64, operand/result width; must be 64
TAG_W, 5, width of pass-through destination tag
CNT_W, 32, width of retired-operation counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream op valid
in_ready  output  1  stage can accept op this cycle
in_alucontrol  input  4  operation code from ALU-control decoder
in_a  input  XLEN  operand A (rs)
in_b  input  XLEN  operand B (rt or sign-extended immediate)
in_tag  input  TAG_W  destination register tag
flush  input  1  synchronous kill of all held ops
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_result  output  XLEN  ALU result
out_zero  output  1  out_result == 0
out_ovf  output  1  signed overflow on arithmetic op
out_illegal  output  1  unsupported alucontrol code
out_tag  output  TAG_W  tag of the op in out_result
retired_cnt  output  CNT_W  count of output handshakes

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid empty, in_ready=1, out_result=0, out_zero=0, out_ovf=0, out_illegal=0, out_tag=0, retired_cnt=0. Reset asserted mid-operation discards all held ops immediately.
- Opcode map (combinational compute on accepted input):
  - 0000 AND: a&b, 64-bit.
  - 0001 OR: a|b, 64-bit.
  - 0010 ADD: 32-bit sum a[31:0]+b[31:0], sign-extended to 64. ovf when signed 32-bit overflow.
  - 0110 SUB: 32-bit a[31:0]-b[31:0], sign-extended. ovf when signed 32-bit overflow.
  - 0111 SLT: 1 if signed 64-bit a<b, else 0. ovf=0.
  - 0011 NOP: result 0, ovf=0.
  - 1010 DADD and 1111 DADDI: 64-bit a+b. ovf when signed 64-bit overflow.
  - 1110 DSUB: 64-bit a-b, signed 64-bit ovf.
  - Any other code: result 0, ovf=0, illegal=1. The op still flows and retires.
  - zero is computed from the final 64-bit result.
  - On overflow the wrapped result is still delivered; trap handling is downstream.
- Handshake: input accepted when in_valid&&in_ready; output transfers when out_valid&&out_ready.
- Latency: an op accepted in cycle N appears on out_* in cycle N+1 when the output register is free or draining that cycle.
- Storage: output register plus one skid entry.
  - in_ready is registered and equals !skid_valid.
  - If out_valid && !out_ready at the moment of acceptance, the new op goes to the skid entry.
  - When the output transfers and the skid is full, the skid moves to the output register and the skid is emptied.
  - If the skid is empty and a new op is accepted in the same cycle as a transfer, the new op loads the output register directly.
  - Order is strictly preserved. out_* fields are stable while out_valid && !out_ready.
- flush (synchronous, highest priority after reset):
  - Next cycle out_valid=0, skid empty, in_ready=1.
  - An op presented in the flush cycle is not accepted.
  - An output handshake occurring in the flush cycle still counts.
  - Data fields are held (don't-care).
- retired_cnt: increments by 1 on each output handshake and wraps from 2^CNT_W-1 to 0. It is unaffected by flush.
- Simultaneous accept and transfer with a full skid cannot occur, because in_ready=0 in that case.

Test Plan:
- ADD overflow: code 0010, a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_result=0xFFFFFFFF80000000, out_ovf=1, out_zero=0, retired_cnt=1.
- DSUB/SLT: code 1110, a=0, b=1 -> result 0xFFFFFFFFFFFFFFFF, ovf=0. Then code 0111, a=0xFFFFFFFFFFFFFFFF, b=0 -> result 1. Then code 1010, a=5, b=-5 -> result 0, zero=1.
- Backpressure: out_ready=0, drive 3 back-to-back ops tagged 1, 2, 3 -> ops 1 and 2 accepted, in_ready=0 from the cycle after op 2. Raise out_ready -> tags emerge 1, 2, 3 in order with no duplicates, and retired_cnt=3.
- Illegal code 0101, a=3, b=4 -> out_result=0, out_illegal=1, out_ovf=0, op retires.
- Flush with output and skid full -> next cycle out_valid=0, in_ready=1, no further outputs. A new op issued after that has latency 1.
- Reset mid-stream: assert rst_n=0 asynchronously between edges while out_valid=1 -> out_valid=0 and retired_cnt=0 immediately. After release, first op behaves normally. Also preload the counter near 2^CNT_W-1 (small CNT_W) and confirm it wraps to 0.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU for the MIPS64 pipeline: computes one op per accepted input and
// holds results in a valid/ready output register backed by a one-entry skid buffer.
module alu_exec_stage #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alucontrol,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_NOP   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_DADD  = 4'b1010;
  localparam logic [3:0] OP_DSUB  = 4'b1110;
  localparam logic [3:0] OP_DADDI = 4'b1111;

  // Returns {illegal, ovf, result}; overflowed results are delivered wrapped.
  function automatic logic [XLEN+1:0] alu_compute(input logic [3:0] op,
                                                  input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [31:0]     s32;
    logic [XLEN-1:0] s64;
    logic [XLEN-1:0] res;
    logic            ovf;
    logic            ill;
    s32 = 32'd0;
    s64 = {XLEN{1'b0}};
    res = {XLEN{1'b0}};
    ovf = 1'b0;
    ill = 1'b0;
    case (op)
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_ADD: begin
        s32 = a[31:0] + b[31:0];
        res = {{(XLEN-32){s32[31]}}, s32};
        ovf = (a[31] == b[31]) && (s32[31] != a[31]);
      end
      OP_SUB: begin
        s32 = a[31:0] - b[31:0];
        res = {{(XLEN-32){s32[31]}}, s32};
        ovf = (a[31] != b[31]) && (s32[31] != a[31]);
      end
      OP_SLT: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NOP: res = {XLEN{1'b0}};
      OP_DADD, OP_DADDI: begin
        s64 = a + b;
        res = s64;
        ovf = (a[XLEN-1] == b[XLEN-1]) && (s64[XLEN-1] != a[XLEN-1]);
      end
      OP_DSUB: begin
        s64 = a - b;
        res = s64;
        ovf = (a[XLEN-1] != b[XLEN-1]) && (s64[XLEN-1] != a[XLEN-1]);
      end
      default: ill = 1'b1;
    endcase
    return {ill, ovf, res};
  endfunction

  logic             in_ready_r, out_valid_r, skid_valid_r;
  logic [XLEN-1:0]  out_result_r, skid_result_r;
  logic             out_zero_r, out_ovf_r, out_illegal_r;
  logic             skid_zero_r, skid_ovf_r, skid_illegal_r;
  logic [TAG_W-1:0] out_tag_r, skid_tag_r;
  logic [CNT_W-1:0] cnt_r;

  logic [XLEN+1:0]  calc_s;
  logic             calc_zero_s, accept_s, xfer_s;
  logic             load_from_in_s, load_from_skid_s, load_skid_s;
  logic             out_valid_nxt_s, skid_valid_nxt_s;

  assign calc_s      = alu_compute(in_alucontrol, in_a, in_b);
  assign calc_zero_s = (calc_s[XLEN-1:0] == {XLEN{1'b0}});
  assign accept_s    = in_valid && in_ready_r;
  assign xfer_s      = out_valid_r && out_ready;

  // Steering: the output register refills from the skid first so order is preserved.
  always_comb begin
    load_from_in_s   = 1'b0;
    load_from_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    out_valid_nxt_s  = out_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      out_valid_nxt_s  = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (xfer_s || !out_valid_r) begin
      if (skid_valid_r) begin
        load_from_skid_s = 1'b1;
        out_valid_nxt_s  = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        load_from_in_s  = 1'b1;
        out_valid_nxt_s = 1'b1;
      end else begin
        out_valid_nxt_s = 1'b0;
      end
    end else if (accept_s) begin
      load_skid_s      = 1'b1;
      skid_valid_nxt_s = 1'b1;
    end else begin
      load_skid_s = 1'b0;
    end
  end

  // Handshake state and retired counter; the counter ignores flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      out_valid_r  <= out_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
      if (xfer_s) cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Result/flag/tag payload for the output register and skid entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result_r   <= {XLEN{1'b0}};
      out_zero_r     <= 1'b0;
      out_ovf_r      <= 1'b0;
      out_illegal_r  <= 1'b0;
      out_tag_r      <= {TAG_W{1'b0}};
      skid_result_r  <= {XLEN{1'b0}};
      skid_zero_r    <= 1'b0;
      skid_ovf_r     <= 1'b0;
      skid_illegal_r <= 1'b0;
      skid_tag_r     <= {TAG_W{1'b0}};
    end else begin
      if (load_from_in_s) begin
        out_result_r  <= calc_s[XLEN-1:0];
        out_zero_r    <= calc_zero_s;
        out_ovf_r     <= calc_s[XLEN];
        out_illegal_r <= calc_s[XLEN+1];
        out_tag_r     <= in_tag;
      end else if (load_from_skid_s) begin
        out_result_r  <= skid_result_r;
        out_zero_r    <= skid_zero_r;
        out_ovf_r     <= skid_ovf_r;
        out_illegal_r <= skid_illegal_r;
        out_tag_r     <= skid_tag_r;
      end
      if (load_skid_s) begin
        skid_result_r  <= calc_s[XLEN-1:0];
        skid_zero_r    <= calc_zero_s;
        skid_ovf_r     <= calc_s[XLEN];
        skid_illegal_r <= calc_s[XLEN+1];
        skid_tag_r     <= in_tag;
      end
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_zero    = out_zero_r;
  assign out_ovf     = out_ovf_r;
  assign out_illegal = out_illegal_r;
  assign out_tag     = out_tag_r;
  assign retired_cnt = cnt_r;

endmodule
